// File: rtl/cache_req_pkg.sv
// Shared constants for the CPU-side cache requester: FSM encodings, rw
// polarity and the default watchdog limit.
package cache_req_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int unsigned DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/cache_requester_if.sv
// Core-side request/response handshake plus the cache processor-port signals.
// master = the requester, slave = core + cache side.
interface cache_requester_if #(
  parameter int unsigned d_width = 4,
  parameter int unsigned a_width = 8
);

  // core request / response
  logic               req_valid;
  logic               req_ready;
  logic               req_rw;
  logic [a_width-1:0] req_addr;
  logic [d_width-1:0] req_wdata;
  logic               resp_valid;
  logic               resp_err;
  logic [d_width-1:0] resp_rdata;

  // cache processor port
  logic [a_width-1:0] c_addr;
  logic [d_width-1:0] c_data;
  logic               c_rw;
  logic               c_ce;
  logic               c_odv;
  logic [d_width-1:0] c_rdata;

  modport master (
    input  req_valid, req_rw, req_addr, req_wdata, c_odv, c_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata, c_addr, c_data, c_rw, c_ce
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_wdata, c_odv, c_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, c_addr, c_data, c_rw, c_ce
  );

endinterface

// File: rtl/req_watchdog.sv
// Saturating access watchdog. Counts enabled cycles since the last clear;
// expired_o is high during the cycle that is the timeout-th enabled cycle
// (and stays high while saturated).
module req_watchdog #(
  parameter int unsigned timeout = 15
) (
  input  logic clk,
  input  logic clr,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(timeout + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(timeout);
  localparam logic [CntW-1:0] CntLast = CntW'(timeout - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Clear wins over enable; count stops at timeout instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of enabled cycles already completed.
  assign expired_o = (cnt_q >= CntLast);

endmodule

// File: rtl/cache_requester.sv
// CPU-side initiator for the cache processor port: accepts one request,
// drives it to the cache until odv or watchdog expiry, then pulses a response.
module cache_requester
  import cache_req_pkg::*;
#(
  parameter int unsigned d_width = 4,
  parameter int unsigned a_width = 8,
  parameter int unsigned timeout = DEFAULT_TIMEOUT
) (
  input logic              clk,
  input logic              clr,
  cache_requester_if.master bus
);

  state_e             state_q, state_d;
  logic               c_ce_q, c_ce_d;
  logic               c_rw_q, c_rw_d;
  logic [a_width-1:0] c_addr_q, c_addr_d;
  logic [d_width-1:0] c_data_q, c_data_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;
  logic [d_width-1:0] resp_rdata_q, resp_rdata_d;

  logic wd_clear;
  logic wd_en;
  logic wd_expired;

  req_watchdog #(
    .timeout (timeout)
  ) u_watchdog (
    .clk       (clk),
    .clr       (clr),
    .clear_i   (wd_clear),
    .en_i      (wd_en),
    .expired_o (wd_expired)
  );

  // Next-state and next-output logic; all outputs except req_ready are registered.
  always_comb begin
    state_d      = state_q;
    c_ce_d       = c_ce_q;
    c_rw_d       = c_rw_q;
    c_addr_d     = c_addr_q;
    c_data_d     = c_data_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    wd_clear     = 1'b0;
    wd_en        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          c_rw_d   = bus.req_rw;
          c_addr_d = bus.req_addr;
          c_data_d = bus.req_wdata;
          c_ce_d   = 1'b1;
          wd_clear = 1'b1;
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        wd_en = 1'b1;
        // odv takes priority over a simultaneous watchdog expiry.
        if (bus.c_odv) begin
          if (c_rw_q == RW_READ) begin
            resp_rdata_d = bus.c_rdata;
          end
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          c_ce_d       = 1'b0;
          state_d      = ST_RESP;
        end else if (wd_expired) begin
          resp_err_d   = 1'b1;
          resp_valid_d = 1'b1;
          c_ce_d       = 1'b0;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        c_ce_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; async reset discards any in-flight access.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= ST_IDLE;
      c_ce_q       <= 1'b0;
      c_rw_q       <= RW_READ;
      c_addr_q     <= '0;
      c_data_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      c_ce_q       <= c_ce_d;
      c_rw_q       <= c_rw_d;
      c_addr_q     <= c_addr_d;
      c_data_q     <= c_data_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Gated by clr so ready is low throughout reset and rises as soon as it releases.
  assign bus.req_ready  = (state_q == ST_IDLE) && clr;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.c_ce       = c_ce_q;
  assign bus.c_rw       = c_rw_q;
  assign bus.c_addr     = c_addr_q;
  assign bus.c_data     = c_data_q;

endmodule

// File: tb/tb_cache_requester.sv
// Directed + randomized bench for cache_requester with a transaction-level model.
module tb_cache_requester;
  import cache_req_pkg::*;

  localparam int unsigned DW = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned TO = 15;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  cache_requester_if #(.d_width(DW), .a_width(AW)) bus ();

  cache_requester #(
    .d_width (DW),
    .a_width (AW),
    .timeout (TO)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state: what resp_rdata / resp_err should currently show.
  logic [DW-1:0] m_rdata = '0;
  logic          m_err   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle of each c_ce rising edge as seen on the DUT output.
  logic prev_ce = 1'b0;
  int   ce_rise_cyc = 0;
  always @(negedge clk) begin
    if (bus.c_ce && !prev_ce) ce_rise_cyc <= cyc;
    prev_ce <= bus.c_ce;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request: odv_cyc = ACCESS cycle (1-based) in which the cache answers,
  // 0 or > TO means never. hold keeps req_valid high with a read of nxt_addr.
  task automatic txn(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                     input int odv_cyc, input logic [DW-1:0] rdata,
                     input bit hold, input logic [AW-1:0] nxt_addr);
    int k;
    bit done;
    bit answered;
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(negedge clk);
    chk("idle_ready", 32'(bus.req_ready), 1);
    chk("idle_ce", 32'(bus.c_ce), 0);
    chk("idle_resp_valid", 32'(bus.resp_valid), 0);
    @(posedge clk);
    #1;
    if (hold) begin
      bus.req_rw   = RW_READ;
      bus.req_addr = nxt_addr;
    end else begin
      bus.req_valid = 1'b0;
      bus.req_rw    = 1'($urandom);
      bus.req_addr  = AW'($urandom);
      bus.req_wdata = DW'($urandom);
    end
    k = 0;
    done = 1'b0;
    while (!done) begin
      k++;
      bus.c_odv   = (k == odv_cyc);
      bus.c_rdata = (k == odv_cyc) ? rdata : DW'($urandom);
      @(negedge clk);
      chk("acc_ce", 32'(bus.c_ce), 1);
      chk("acc_addr", 32'(bus.c_addr), 32'(addr));
      chk("acc_data", 32'(bus.c_data), 32'(wdata));
      chk("acc_rw", 32'(bus.c_rw), 32'(rw));
      chk("acc_ready", 32'(bus.req_ready), 0);
      chk("acc_resp_valid", 32'(bus.resp_valid), 0);
      chk("acc_rdata_held", 32'(bus.resp_rdata), 32'(m_rdata));
      done = (k == odv_cyc) || (k >= int'(TO));
      @(posedge clk);
      #1;
    end
    answered = (odv_cyc >= 1) && (odv_cyc <= int'(TO));
    if (answered) begin
      m_err = 1'b0;
      if (rw == RW_READ) m_rdata = rdata;
    end else begin
      m_err = 1'b1;
    end
    // odv in RESP must be ignored
    bus.c_odv   = 1'($urandom);
    bus.c_rdata = DW'($urandom);
    @(negedge clk);
    chk("resp_valid", 32'(bus.resp_valid), 1);
    chk("resp_err", 32'(bus.resp_err), 32'(m_err));
    chk("resp_rdata", 32'(bus.resp_rdata), 32'(m_rdata));
    chk("resp_ce_low", 32'(bus.c_ce), 0);
    chk("resp_ready", 32'(bus.req_ready), 0);
    @(posedge clk);
    #1;
    bus.c_odv = 1'b0;
  endtask

  task automatic idle_check();
    bus.c_odv = 1'($urandom);
    @(negedge clk);
    chk("post_ready", 32'(bus.req_ready), 1);
    chk("post_resp_valid", 32'(bus.resp_valid), 0);
    chk("post_err_held", 32'(bus.resp_err), 32'(m_err));
    chk("post_rdata_held", 32'(bus.resp_rdata), 32'(m_rdata));
    chk("post_ce", 32'(bus.c_ce), 0);
    @(posedge clk);
    #1;
    bus.c_odv = 1'b0;
  endtask

  int r1;
  int r2;

  initial begin
    clr           = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.c_odv     = 1'b0;
    bus.c_rdata   = '0;

    // Reset values
    #12;
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_resp_err", 32'(bus.resp_err), 0);
    chk("rst_resp_rdata", 32'(bus.resp_rdata), 0);
    chk("rst_ce", 32'(bus.c_ce), 0);
    chk("rst_rw", 32'(bus.c_rw), 1);
    chk("rst_addr", 32'(bus.c_addr), 0);
    chk("rst_data", 32'(bus.c_data), 0);
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("rel_ready", 32'(bus.req_ready), 1);
    @(posedge clk);
    #1;

    // Read, odv in 2nd ACCESS cycle
    txn(RW_READ, 8'h3C, 4'h0, 2, 4'hA, 1'b0, 8'h00);
    // Write, odv in 1st ACCESS cycle; garbage rdata must not be captured
    txn(RW_WRITE, 8'h10, 4'h5, 1, 4'hC, 1'b0, 8'h00);
    // Timeout
    txn(RW_READ, 8'hFF, 4'h3, 0, 4'h0, 1'b0, 8'h00);
    idle_check();
    // Race: odv on the expiring cycle
    txn(RW_READ, 8'h22, 4'h1, int'(TO), 4'h7, 1'b0, 8'h00);
    idle_check();

    // Back-to-back with req_valid held
    txn(RW_READ, 8'h01, 4'h0, 1, 4'h9, 1'b1, 8'h02);
    r1 = ce_rise_cyc;
    txn(RW_READ, 8'h02, 4'h0, 1, 4'h4, 1'b0, 8'h00);
    r2 = ce_rise_cyc;
    chk("b2b_gap", 32'(r2 - r1), 3);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      txn(1'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(0, TO + 2)),
          DW'($urandom), 1'b0, 8'h00);
      if (($urandom % 3) == 0) idle_check();
    end
    idle_check();

    // Reset in the middle of an access
    bus.req_valid = 1'b1;
    bus.req_rw    = RW_READ;
    bus.req_addr  = 8'h5A;
    bus.req_wdata = 4'h6;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("mid_ce_before", 32'(bus.c_ce), 1);
    #2;
    clr = 1'b0;
    #1;
    chk("mid_rst_ce", 32'(bus.c_ce), 0);
    chk("mid_rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("mid_rst_ready", 32'(bus.req_ready), 0);
    m_rdata = '0;
    m_err   = 1'b0;
    @(posedge clk);
    #3;
    clr = 1'b1;
    #1;
    chk("mid_rel_ready", 32'(bus.req_ready), 1);
    for (int i = 0; i < 5; i++) begin
      bus.c_odv = 1'($urandom);
      @(negedge clk);
      chk("mid_no_resp", 32'(bus.resp_valid), 0);
      chk("mid_ce_low", 32'(bus.c_ce), 0);
      chk("mid_rdata", 32'(bus.resp_rdata), 32'(m_rdata));
      @(posedge clk);
      #1;
    end
    bus.c_odv = 1'b0;
    txn(RW_READ, 8'h77, 4'h2, 3, 4'hB, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_requester.md
Name: cache_requester

Overview:
CPU-side initiator for the cache's processor port. It accepts single read/write requests from the core over a valid/ready handshake and drives addr/data/rw/ce into the cache. It then waits for the cache's odv (output data valid) strobe and returns read data or completion status to the core. A watchdog flags accesses that the cache never acknowledges.

Parameters:
d_width, 4, data bus width (matches cache/RAM d_width)
a_width, 8, address width (matches cache/RAM a_width)
timeout, 15, max cycles in ACCESS without odv before error; must be >=1, counter width 4 bits at default

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-low reset
req_valid  input  1  core request present
req_ready  output  1  requester can accept a request
req_rw  input  1  1 = read, 0 = write
req_addr  input  a_width  request address
req_wdata  input  d_width  write data
resp_valid  output  1  one-cycle pulse: request finished
resp_err  output  1  qualifies resp_valid: 1 = timeout
resp_rdata  output  d_width  read data, held until next successful read
c_addr  output  a_width  address to cache
c_data  output  d_width  write data to cache
c_rw  output  1  rw to cache (1 read, 0 write)
c_ce  output  1  chip enable to cache
c_odv  input  1  cache output-data-valid / write-acknowledge strobe
c_rdata  input  d_width  read data from cache, valid when c_odv=1

Behaviour:
- Reset (clr=0, async): state=IDLE; req_ready=0 while clr=0, then 1 after release; resp_valid=0; resp_err=0; resp_rdata=0; c_ce=0; c_rw=1; c_addr=0; c_data=0; watchdog=0. Reset during ACCESS drops c_ce immediately, and the request is discarded with no response.
- States: IDLE, ACCESS, RESP. Encoding is 2 bits; the unused code returns to IDLE.
- IDLE: req_ready=1. On req_valid&req_ready at edge N: latch req_rw/req_addr/req_wdata into c_rw/c_addr/c_data, clear the watchdog, and go to ACCESS. c_ce=1 from cycle N+1.
- ACCESS: req_ready=0; c_ce, c_addr, c_rw, c_data are held stable; the watchdog increments each cycle.
  - If c_odv=1: capture c_rdata into resp_rdata (reads only; writes leave resp_rdata unchanged), set resp_err=0, go to RESP.
  - Else, if the watchdog reaches timeout: set resp_err=1, leave resp_rdata unchanged, go to RESP.
  - If c_odv=1 in the same cycle the watchdog reaches timeout: odv wins, resp_err=0.
- RESP: c_ce=0; resp_valid=1 for exactly one cycle; req_ready=0; next state is IDLE. resp_err holds its value until the next RESP.
- Latency: request accepted at edge N, c_ce high in cycle N+1. If c_odv arrives in cycle N+k (k>=1), resp_valid is high in cycle N+k+1. Minimum turnaround from accept to the next accept is 3 cycles.
- c_odv is ignored in IDLE and RESP, with no state change.
- req_valid in ACCESS/RESP is not accepted; the core must hold the request until req_ready.
- c_ce never stays high across a RESP cycle, so the cache always sees a ce low gap between accesses.
- The watchdog saturates at timeout and never wraps.

Decomposition:
- Package cache_req_pkg: state encodings ST_IDLE/ST_ACCESS/ST_RESP, RW_READ=1 / RW_WRITE=0, default timeout constant.
- One sub-module, req_watchdog: clear/enable/saturating counter with a "expired" output, parameterised on timeout. The FSM and the datapath latches stay in cache_requester.

Test Plan:
- Read: req rw=1 addr=0x3C, cache returns c_rdata=0xA with c_odv in the 2nd ACCESS cycle -> resp_valid one cycle later, resp_rdata=0xA, resp_err=0, c_ce high exactly 2 cycles.
- Write: rw=0 addr=0x10 wdata=0x5, odv after 1 cycle -> c_data=0x5 and c_addr=0x10 stable while ce=1, resp_valid with resp_err=0, resp_rdata keeps previous 0xA.
- Timeout: read addr=0xFF, c_odv never asserted -> after 15 ACCESS cycles resp_valid=1 and resp_err=1, resp_rdata unchanged, FSM returns to IDLE with req_ready=1.
- Race: c_odv=1 with c_rdata=0x7 on the cycle the watchdog expires -> resp_err=0, resp_rdata=0x7.
- Back-to-back: req_valid held high with two reads (0x01, 0x02) -> second accept exactly 3 cycles after the first, c_ce low for the one RESP cycle between them.
- Reset mid-access: clr=0 during ACCESS -> c_ce=0 and resp_valid=0 immediately (same cycle, asynchronous), no response pulse after release, req_ready=1 once clr returns high.
